mmio_slot_master: RTL and testbench
===================================

MMIO_SLOT_MASTER -- requirements
Module: mmio_slot_master

Interface
REQ-001 Parameter NUM_SLOTS, default 8: number of slot responders on the bus.
REQ-002 Parameter TIMEOUT_CYCLES, default 64: maximum cycles to wait in WAIT for a done pulse.
REQ-003 Parameter SLOT_BITS, default $clog2(NUM_SLOTS): width of the slot-index field.
REQ-004 clk  in  1  clock; reset arst_n, asynchronous, active-low.
REQ-005 arst_n  in  1  asynchronous active-low reset.
REQ-006 req_valid  in  1  upstream request present.
REQ-007 req_ready  out  1  request accepted when high together with req_valid.
REQ-008 req_write  in  1  1=write, 0=read.
REQ-009 req_addr  in  32  [8+:SLOT_BITS]=slot index, [7:0]=register offset, other bits ignored.
REQ-010 req_wdata  in  32  write data.
REQ-011 rsp_valid  out  1  response present; held until rsp_ready.
REQ-012 rsp_ready  in  1  upstream consumes response.
REQ-013 rsp_rdata  out  32  read data; 0 for writes and for errors.
REQ-014 rsp_err  out  2  OKAY/SLVERR/DECERR/TIMEOUT.
REQ-015 chip_select  out  NUM_SLOTS  one-hot slot select.
REQ-016 read, write  out  1 each  slot operation strobes, level-held.
REQ-017 transaction_completed  out  1  one-cycle release pulse to the selected slot.
REQ-018 addr  out  8; wr_data  out  32  shared slot bus.
REQ-019 slot_rd_data  in  NUM_SLOTS x 32  per-slot read data.
REQ-020 rd_done, wr_done, slave_error, decode_error  in  NUM_SLOTS each  per-slot status.

Function
REQ-021 FSM states: IDLE, WAIT, COMPLETE, RESP.
REQ-022 IDLE: req_ready=1; on req_valid, latch write, slot, offset, and wdata into registers.
REQ-023 IDLE, slot index >= NUM_SLOTS: go to RESP with rsp_err=DECERR and never drive the bus.
REQ-024 IDLE, otherwise: go to WAIT.
REQ-025 WAIT: drive chip_select[slot]=1, read=~write_r, write=write_r, addr, and wr_data from the latched registers, all stable the whole state.
REQ-026 WAIT: monitor only the selected slot's rd_done (reads) or wr_done (writes), sampled every cycle, because done is a single-cycle pulse.
REQ-027 On the done pulse, capture slot_rd_data (reads only) and the error bits in the same cycle, then go to COMPLETE.
REQ-028 Error mapping: decode_error gives DECERR (priority), else slave_error gives SLVERR, else OKAY.
REQ-029 On SLVERR or DECERR, rsp_rdata shall be 0.
REQ-030 Timeout counter: cleared on entering WAIT, incremented each WAIT cycle.
REQ-031 If the count reaches TIMEOUT_CYCLES-1 with no done, set rsp_err=TIMEOUT, rsp_rdata=0, and go to COMPLETE.
REQ-032 If done and timeout expiry occur in the same cycle, done wins.
REQ-033 COMPLETE (1 cycle): transaction_completed=1 and chip_select/read/write=0, so the responder returns to idle without retriggering; then go to RESP.
REQ-034 RESP: rsp_valid=1 with stable rsp_rdata/rsp_err; on rsp_ready go to IDLE; req_ready=0.
REQ-035 Latency with a zero-wait responder: acceptance at cycle 0, bus driven cycles 1-2, done seen cycle 3, COMPLETE cycle 4, rsp_valid cycle 5.
REQ-036 A done pulse from a non-selected slot, or a done pulse outside WAIT, shall be ignored.
REQ-037 Back-to-back: a new request is accepted no earlier than the cycle after the RESP handshake.

Reset
REQ-038 arst_n low forces IDLE immediately, including mid-transaction.
REQ-039 On reset, all outputs shall be 0 except req_ready=1; rsp_rdata=0; rsp_err=OKAY; timeout counter=0.

Structure
REQ-040 Package mmio_pkg holds enum rsp_err_t (OKAY=0, SLVERR=1, DECERR=2, TIMEOUT=3), the slot offset width (8), and the data width (32).
REQ-041 The block is a single module; the FSM state enum is local to it; no sub-module.

Verification
REQ-042 Read slot 0, addr 0x008, responder returns 0x0000_0123 with rd_done at cycle 3 -> rsp_valid at cycle 5, rsp_rdata=0x123, rsp_err=OKAY, transaction_completed pulsed exactly once.
REQ-043 Write slot 2, addr 0x204, data 0xA5 -> chip_select=8'b0000_0100, addr=0x04, wr_data=0xA5 held until wr_done; then OKAY.
REQ-044 Read slot 1 returning slave_error=1 and decode_error=1 -> rsp_err=DECERR, rsp_rdata=0.
REQ-045 Responder never asserts done, TIMEOUT_CYCLES=64 -> rsp_err=TIMEOUT after 64 WAIT cycles, transaction_completed pulsed, bus released.
REQ-046 NUM_SLOTS=5, req_addr=0x600 -> immediate DECERR and chip_select stays 0.
REQ-047 rsp_ready held low for 10 cycles, then arst_n asserted -> rsp_valid drops asynchronously, req_ready=1 after reset, and the next read completes normally.

Source files
------------

// File: rtl/mmio_pkg.sv
// Shared types and widths for the MMIO slot master and its bus interface.
package mmio_pkg;

  localparam int REQ_ADDR_W = 32;
  localparam int OFFSET_W   = 8;
  localparam int DATA_W     = 32;

  typedef enum logic [1:0] {
    OKAY    = 2'd0,
    SLVERR  = 2'd1,
    DECERR  = 2'd2,
    TIMEOUT = 2'd3
  } rsp_err_t;

  // A responder flagging both errors reports the decode error.
  function automatic rsp_err_t status_to_err(input logic slave_error, input logic decode_error);
    if (decode_error) return DECERR;
    if (slave_error) return SLVERR;
    return OKAY;
  endfunction

endpackage

// File: rtl/mmio_slot_master_if.sv
// Upstream request/response channel plus the shared slot bus, seen from the master.
interface mmio_slot_master_if #(
  parameter int NUM_SLOTS = 8
);
  import mmio_pkg::*;

  logic                              req_valid;
  logic                              req_ready;
  logic                              req_write;
  logic [REQ_ADDR_W-1:0]             req_addr;
  logic [DATA_W-1:0]                 req_wdata;

  logic                              rsp_valid;
  logic                              rsp_ready;
  logic [DATA_W-1:0]                 rsp_rdata;
  rsp_err_t                          rsp_err;

  logic [NUM_SLOTS-1:0]              chip_select;
  logic                              read;
  logic                              write;
  logic                              transaction_completed;
  logic [OFFSET_W-1:0]               addr;
  logic [DATA_W-1:0]                 wr_data;

  logic [NUM_SLOTS-1:0][DATA_W-1:0]  slot_rd_data;
  logic [NUM_SLOTS-1:0]              rd_done;
  logic [NUM_SLOTS-1:0]              wr_done;
  logic [NUM_SLOTS-1:0]              slave_error;
  logic [NUM_SLOTS-1:0]              decode_error;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
           slot_rd_data, rd_done, wr_done, slave_error, decode_error,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
           chip_select, read, write, transaction_completed, addr, wr_data
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, rsp_ready,
           slot_rd_data, rd_done, wr_done, slave_error, decode_error,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
           chip_select, read, write, transaction_completed, addr, wr_data
  );

endinterface

// File: rtl/mmio_slot_master.sv
// Single-outstanding MMIO master: decodes a slot index, holds the slot bus until a
// done pulse or timeout, releases the responder, then returns one response.
module mmio_slot_master
  import mmio_pkg::*;
#(
  parameter int NUM_SLOTS      = 8,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int SLOT_BITS      = $clog2(NUM_SLOTS)
) (
  input  logic               clk,
  input  logic               arst_n,
  mmio_slot_master_if.master bus
);

  typedef enum logic [1:0] {IDLE, WAIT, COMPLETE, RESP} state_t;

  localparam int                 CNT_W      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [SLOT_BITS:0] SLOT_LIMIT = (SLOT_BITS + 1)'(NUM_SLOTS);

  state_t                state_q, state_d;
  logic                  write_q, write_d;
  logic [SLOT_BITS-1:0]  slot_q, slot_d;
  logic [OFFSET_W-1:0]   offset_q, offset_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic [DATA_W-1:0]     rdata_q, rdata_d;
  rsp_err_t              err_q, err_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  logic [SLOT_BITS-1:0]  req_slot;
  logic                  slot_out_of_range;
  logic                  done;
  rsp_err_t              done_err;
  logic                  unused_addr_bits;

  assign req_slot          = bus.req_addr[OFFSET_W +: SLOT_BITS];
  assign slot_out_of_range = ({1'b0, req_slot} >= SLOT_LIMIT);
  assign unused_addr_bits  = ^bus.req_addr[REQ_ADDR_W-1:OFFSET_W+SLOT_BITS];

  // Only the selected slot's done of the matching direction may end WAIT.
  assign done     = write_q ? bus.wr_done[slot_q] : bus.rd_done[slot_q];
  assign done_err = status_to_err(bus.slave_error[slot_q], bus.decode_error[slot_q]);

  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q  <= IDLE;
      write_q  <= 1'b0;
      slot_q   <= '0;
      offset_q <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      err_q    <= OKAY;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      write_q  <= write_d;
      slot_q   <= slot_d;
      offset_q <= offset_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    write_d  = write_q;
    slot_d   = slot_q;
    offset_d = offset_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    cnt_d    = cnt_q;

    bus.req_ready             = 1'b0;
    bus.rsp_valid             = 1'b0;
    bus.chip_select           = '0;
    bus.read                  = 1'b0;
    bus.write                 = 1'b0;
    bus.transaction_completed = 1'b0;
    bus.addr                  = '0;
    bus.wr_data               = '0;

    case (state_q)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          write_d  = bus.req_write;
          slot_d   = req_slot;
          offset_d = bus.req_addr[OFFSET_W-1:0];
          wdata_d  = bus.req_wdata;
          // A slot with no responder is answered without touching the bus.
          if (slot_out_of_range) begin
            err_d   = DECERR;
            rdata_d = '0;
            state_d = RESP;
          end else begin
            cnt_d   = '0;
            state_d = WAIT;
          end
        end
      end

      WAIT: begin
        bus.chip_select = NUM_SLOTS'(1) << slot_q;
        bus.read        = ~write_q;
        bus.write       = write_q;
        bus.addr        = offset_q;
        bus.wr_data     = wdata_q;
        cnt_d           = cnt_q + 1'b1;
        if (done) begin
          err_d   = done_err;
          rdata_d = (!write_q && done_err == OKAY) ? bus.slot_rd_data[slot_q] : '0;
          state_d = COMPLETE;
        end else if (cnt_q == CNT_LAST) begin
          err_d   = TIMEOUT;
          rdata_d = '0;
          state_d = COMPLETE;
        end
      end

      COMPLETE: begin
        bus.transaction_completed = 1'b1;
        state_d                   = RESP;
      end

      RESP: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mmio_slot_master.sv
// Directed and randomized transactions against a cycle-level reference model of the
// slot master's handshake, latency, error mapping and timeout rules.
module tb_mmio_slot_master;
  import mmio_pkg::*;

  localparam int NS = 5;
  localparam int TO = 64;

  logic clk = 1'b0;
  logic arst_n;
  always #5 clk = ~clk;

  mmio_slot_master_if #(.NUM_SLOTS(NS)) bus ();

  mmio_slot_master #(
    .NUM_SLOTS      (NS),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk    (clk),
    .arst_n (arst_n),
    .bus    (bus)
  );

  int checks   = 0;
  int failures = 0;
  int txn_id   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL txn%0d %s observed=0x%0h expected=0x%0h", txn_id, tag, obs, exp);
    end
  endtask

  task automatic quiet();
    bus.req_valid    = 1'b0;
    bus.req_write    = 1'b0;
    bus.req_addr     = '0;
    bus.req_wdata    = '0;
    bus.rsp_ready    = 1'b0;
    bus.slot_rd_data = '0;
    bus.rd_done      = '0;
    bus.wr_done      = '0;
    bus.slave_error  = '0;
    bus.decode_error = '0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_req_ready"}, bus.req_ready, 1);
    check({tag, "_rsp_valid"}, bus.rsp_valid, 0);
    check({tag, "_rsp_rdata"}, bus.rsp_rdata, 0);
    check({tag, "_rsp_err"}, bus.rsp_err, OKAY);
    check({tag, "_cs"}, bus.chip_select, 0);
    check({tag, "_rd_wr"}, {bus.read, bus.write}, 0);
    check({tag, "_txn_completed"}, bus.transaction_completed, 0);
    check({tag, "_addr"}, bus.addr, 0);
    check({tag, "_wr_data"}, bus.wr_data, 0);
  endtask

  // delay: index of the WAIT cycle carrying the done pulse (large value = never).
  // abort_at: cycle at which reset is applied asynchronously (0 = no abort).
  task automatic run_txn(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] slot_data, input int delay,
                         input logic serr, input logic derr,
                         input int rdy_wait, input int abort_at);
    int       slot;
    bit       dec;
    int       wait_len, cpl_cyc, rsp_cyc, hs_cyc;
    rsp_err_t exp_err;
    logic [31:0] exp_rd;

    txn_id++;
    slot     = int'(a[10:8]);
    dec      = (slot >= NS);
    wait_len = dec ? 0 : ((delay < TO) ? delay + 1 : TO);
    cpl_cyc  = dec ? -1 : wait_len + 1;
    rsp_cyc  = dec ? 1 : wait_len + 2;
    hs_cyc   = rsp_cyc + rdy_wait;
    if (dec)              exp_err = DECERR;
    else if (delay >= TO) exp_err = TIMEOUT;
    else if (derr)        exp_err = DECERR;
    else if (serr)        exp_err = SLVERR;
    else                  exp_err = OKAY;
    exp_rd = (!wr && exp_err == OKAY) ? slot_data : 32'h0;

    check("accept_req_ready", bus.req_ready, 1);
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_addr  = a;
    bus.req_wdata = wd;

    for (int c = 1; c <= hs_cyc + 1; c++) begin
      logic          in_wait;
      logic [NS-1:0] sel, rd_n, wr_n;
      @(negedge clk);
      in_wait = (c <= wait_len);
      sel     = dec ? '0 : (NS'(1) << slot);
      if (c == hs_cyc + 1) begin
        check("post_rsp_valid", bus.rsp_valid, 0);
        check("post_req_ready", bus.req_ready, 1);
        check("post_cs", bus.chip_select, 0);
        quiet();
      end else begin
        check("cs", bus.chip_select, in_wait ? sel : '0);
        check("read", bus.read, in_wait && !wr);
        check("write", bus.write, in_wait && wr);
        if (in_wait) begin
          check("addr", bus.addr, a[7:0]);
          check("wr_data", bus.wr_data, wd);
        end
        check("txn_completed", bus.transaction_completed, c == cpl_cyc);
        check("rsp_valid", bus.rsp_valid, c >= rsp_cyc);
        check("req_ready", bus.req_ready, 0);
        if (c >= rsp_cyc) begin
          check("rsp_rdata", bus.rsp_rdata, exp_rd);
          check("rsp_err", bus.rsp_err, exp_err);
        end

        // Responder activity: noise everywhere except the selected slot's own done.
        rd_n = NS'($urandom);
        wr_n = NS'($urandom);
        if (wr) wr_n &= ~sel; else rd_n &= ~sel;
        bus.slave_error  = NS'($urandom);
        bus.decode_error = NS'($urandom);
        for (int i = 0; i < NS; i++) bus.slot_rd_data[i] = $urandom;
        if (!dec && c == delay + 1) begin
          if (wr) wr_n |= sel; else rd_n |= sel;
          bus.slot_rd_data[slot] = slot_data;
          bus.slave_error[slot]  = serr;
          bus.decode_error[slot] = derr;
        end else if (!dec && !in_wait && $urandom_range(0, 2) == 0) begin
          if (wr) wr_n |= sel; else rd_n |= sel;
        end
        bus.rd_done = rd_n;
        bus.wr_done = wr_n;

        bus.rsp_ready = (c == hs_cyc);
        bus.req_valid = (c >= rsp_cyc);
        if (c >= rsp_cyc) begin
          bus.req_addr  = $urandom;
          bus.req_write = 1'($urandom);
        end

        if (c == abort_at) begin
          #2 arst_n = 1'b0;
          #1 check_reset_state("abort");
          @(negedge clk);
          quiet();
          arst_n = 1'b1;
          return;
        end
      end
    end
  endtask

  initial begin
    logic        r_wr, r_serr, r_derr;
    logic [31:0] r_addr;
    int          r_delay;

    arst_n = 1'b0;
    quiet();
    repeat (2) @(negedge clk);
    check_reset_state("reset");
    arst_n = 1'b1;
    @(negedge clk);

    // wr, addr, wdata, slot data, delay, serr, derr, rdy_wait, abort_at
    run_txn(1'b0, 32'h0000_0008, 32'h0,        32'h0000_0123, 2,    1'b0, 1'b0, 0,  0);
    run_txn(1'b1, 32'h0000_0204, 32'h0000_00A5, 32'h0,        3,    1'b0, 1'b0, 1,  0);
    run_txn(1'b0, 32'h0000_0100, 32'h0,        32'h0000_DEAD, 1,    1'b1, 1'b1, 0,  0);
    run_txn(1'b0, 32'h0000_0310, 32'h0,        32'h0000_0055, 0,    1'b1, 1'b0, 2,  0);
    run_txn(1'b1, 32'h0000_0420, 32'h1234_5678, 32'h0,        0,    1'b1, 1'b0, 0,  0);
    run_txn(1'b0, 32'h0000_0040, 32'h0,        32'h0000_0077, 1000, 1'b0, 1'b0, 0,  0);
    run_txn(1'b0, 32'h0000_0444, 32'h0,        32'hBEEF_0001, 63,   1'b0, 1'b0, 0,  0);
    run_txn(1'b1, 32'h0000_0144, 32'h0000_0F0F, 32'h0,        64,   1'b0, 1'b0, 0,  0);
    run_txn(1'b0, 32'h0000_0600, 32'h0,        32'h0000_0999, 0,    1'b0, 1'b0, 0,  0);
    run_txn(1'b1, 32'hFFFF_F7FF, 32'hAAAA_5555, 32'h0,        0,    1'b0, 1'b0, 3,  0);
    run_txn(1'b0, 32'h0000_00AC, 32'h0,        32'h0000_CAFE, 2,    1'b0, 1'b0, 20, 15);
    run_txn(1'b0, 32'h0000_02AC, 32'h0,        32'h0000_0B0B, 0,    1'b0, 1'b0, 0,  0);
    run_txn(1'b1, 32'h0000_03F0, 32'h0000_1111, 32'h0,        30,   1'b0, 1'b0, 0,  5);
    run_txn(1'b1, 32'h0000_03F0, 32'h0000_2222, 32'h0,        4,    1'b0, 1'b0, 0,  0);

    for (int n = 0; n < 40; n++) begin
      r_wr    = 1'($urandom);
      r_addr  = $urandom;
      r_delay = ($urandom_range(0, 9) == 0) ? int'($urandom_range(60, 70)) : int'($urandom_range(0, 5));
      r_serr  = ($urandom_range(0, 3) == 0);
      r_derr  = ($urandom_range(0, 5) == 0);
      run_txn(r_wr, r_addr, $urandom, $urandom, r_delay, r_serr, r_derr,
              int'($urandom_range(0, 3)), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
